// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed memory with a post-reset fill sequencer,
// a configurable read latency and a handshake-free backdoor write port.
module axi_lite_slave_mem #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 1,
    parameter int FILL_MODE    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    input  logic                    bd_we,
    input  logic [ADDR_WIDTH-1:0]   bd_addr,
    input  logic [DATA_WIDTH-1:0]   bd_wdata,
    input  logic [DATA_WIDTH/8-1:0] bd_wstrb,
    output logic                    init_done
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int WIDX_W = ADDR_WIDTH - LSB;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDX_W-1:0] DEPTH_W  = WIDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]        LAT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic {INIT, READY} init_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    init_state_e       init_state_q;
    logic [IDX_W-1:0]  init_cnt_q;
    logic              init_done_q;

    rd_state_e         r_state_q;
    logic [3:0]        r_cnt_q;
    logic [WIDX_W-1:0] ar_word_q;
    logic              rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              aw_full_q, w_full_q, bvalid_q;
    logic [WIDX_W-1:0] aw_word_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        bresp_q;

    logic [WIDX_W-1:0] aw_word, ar_word, bd_word, rd_word;
    logic              commit, commit_ok, bd_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_data, fill_word;
    logic              unused_addr_bits;

    assign aw_word = s_awaddr[ADDR_WIDTH-1:LSB];
    assign ar_word = s_araddr[ADDR_WIDTH-1:LSB];
    assign bd_word = bd_addr[ADDR_WIDTH-1:LSB];
    assign unused_addr_bits = ^{s_awaddr[LSB-1:0], s_araddr[LSB-1:0], bd_addr[LSB-1:0]};

    assign init_done = init_done_q;
    assign s_awready = init_done_q & ~aw_full_q;
    assign s_wready  = init_done_q & ~w_full_q;
    assign s_arready = init_done_q & (r_state_q == R_IDLE);
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign commit    = aw_full_q & w_full_q & ~bvalid_q;
    assign commit_ok = commit & (aw_word_q < DEPTH_W);
    assign bd_ok     = init_done_q & bd_we & (bd_word < DEPTH_W);
    assign fill_word = (FILL_MODE == 1) ? DATA_WIDTH'(init_cnt_q) : '0;

    // In R_IDLE the sample comes straight from the AR channel (zero-latency path).
    assign rd_word = (r_state_q == R_IDLE) ? ar_word : ar_word_q;
    assign rd_ok   = rd_word < DEPTH_W;
    assign rd_data = mem[rd_word[IDX_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_state_q <= INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            case (init_state_q)
                INIT: begin
                    if (init_cnt_q == LAST_IDX) begin
                        init_state_q <= READY;
                        init_done_q  <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                READY: init_state_q <= READY;
                default: init_state_q <= INIT;
            endcase
        end
    end

    // NOTE: the array has no reset; the INIT sequencer rewrites every word after each reset instead.
    // The AXI commit is written last so its strobed bytes win over a same-word backdoor write.
    always_ff @(posedge clk) begin
        if (init_state_q == INIT) begin
            mem[init_cnt_q] <= fill_word;
        end else begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bd_ok && bd_wstrb[b])
                    mem[bd_word[IDX_W-1:0]][b*8 +: 8] <= bd_wdata[b*8 +: 8];
            end
            for (int b = 0; b < STRB_W; b++) begin
                if (commit_ok && w_strb_q[b])
                    mem[aw_word_q[IDX_W-1:0]][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            ar_word_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_arvalid && s_arready) begin
                        ar_word_q <= ar_word;
                        if (READ_LATENCY == 0) begin
                            r_state_q <= R_RESP;
                            rvalid_q  <= 1'b1;
                            rdata_q   <= rd_ok ? rd_data : '0;
                            rresp_q   <= rd_ok ? 2'b00 : 2'b10;
                        end else begin
                            r_state_q <= R_WAIT;
                            r_cnt_q   <= LAT_INIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == 4'd0) begin
                        r_state_q <= R_RESP;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_ok ? rd_data : '0;
                        rresp_q   <= rd_ok ? 2'b00 : 2'b10;
                    end else begin
                        r_cnt_q <= r_cnt_q - 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Holding registers cannot be refilled on the commit cycle because their readies are low while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full_q <= 1'b0;
            aw_word_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_full_q <= 1'b1;
                aw_word_q <= aw_word;
            end
            if (s_wvalid && s_wready) begin
                w_full_q <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= commit_ok ? 2'b00 : 2'b10;
            end else if (bvalid_q && s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: fill, read latency, write ordering, backdoor merge,
// out-of-range responses and reset during outstanding transactions.
module tb_axi_lite_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, bd_addr, bd_wdata;
    logic [3:0]  s_wstrb, bd_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, bd_we, init_done;
    logic [1:0]  s_bresp, s_rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_slave_mem #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4096), .READ_LATENCY(3), .FILL_MODE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb),
        .init_done(init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out, no response within bound", what);
    endtask

    task automatic bd_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bd_addr = addr; bd_wdata = data; bd_wstrb = strb; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 'x; resp = 'x;
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin tick(); n++; end
        if (!s_arready) begin s_arvalid = 1'b0; timeout_fail("ar_handshake"); return; end
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 50) begin tick(); n++; end
        if (!s_rvalid) begin timeout_fail("rvalid_wait"); return; end
        data = s_rdata; resp = s_rresp;
        tick();
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        int  n;
        logic aw_done, w_done, aw_hs, w_hs;
        resp = 'x;
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; s_bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick(); n++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin s_wvalid = 1'b0; w_done = 1'b1; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done)) begin timeout_fail("aw_w_handshake"); return; end
        n = 0;
        while (!s_bvalid && n < 50) begin tick(); n++; end
        if (!s_bvalid) begin timeout_fail("bvalid_wait"); return; end
        resp = s_bresp;
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) tick();
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, init_done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, init_done});
        end
        checks++;
        if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", s_rdata); end
        checks++;
        if ({s_rresp, s_bresp} !== 4'b0) begin errors++; $display("FAIL reset_resp got %b exp 0000", {s_rresp, s_bresp}); end
        checks++;
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 5000) begin
            tick(); n++;
            if (n == 1) begin
                if ({s_awready, s_wready, s_arready} !== 3'b0) begin
                    errors++; $display("FAIL init_readies got %b exp 000", {s_awready, s_wready, s_arready});
                end
                checks++;
            end
            if (n == 100) begin
                bd_addr = 32'h28; bd_wdata = 32'hFFFF_FFFF; bd_wstrb = 4'hF; bd_we = 1'b1;
            end
            if (n == 101) bd_we = 1'b0;
        end
        if (n !== 4096) begin errors++; $display("FAIL init_cycles got %0d exp 4096", n); end
        checks++;
        axi_read(32'h28, d, r);
        if (d !== 32'h0000_000A) begin errors++; $display("FAIL init_bd_ignored got %h exp 0000000a", d); end
        checks++;
    endtask

    task automatic test_fill_read();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(32'h80, d, r);
        if (d !== 32'h20 || r !== 2'b00) begin errors++; $display("FAIL fill_0x80 got %h/%b exp 00000020/00", d, r); end
        checks++;
        axi_read(32'h3FFC, d, r);
        if (d !== 32'hFFF || r !== 2'b00) begin errors++; $display("FAIL fill_last got %h/%b exp 00000fff/00", d, r); end
        checks++;
        axi_read(32'h83, d, r);
        if (d !== 32'h20) begin errors++; $display("FAIL low_bits_ignored got %h exp 00000020", d); end
        checks++;
    endtask

    task automatic test_read_latency();
        int n;
        s_araddr = 32'h200; s_arvalid = 1'b1; s_rready = 1'b1;
        if (s_arready !== 1'b1) begin errors++; $display("FAIL lat_arready got %b exp 1", s_arready); end
        checks++;
        tick();
        s_arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
                errors++; $display("FAIL lat_wait%0d got rvalid %b arready %b exp 0 0", k, s_rvalid, s_arready);
            end
            checks++;
            tick();
        end
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h80 || s_rresp !== 2'b00) begin
            errors++; $display("FAIL lat_resp got %b/%h/%b exp 1/00000080/00", s_rvalid, s_rdata, s_rresp);
        end
        checks++;
        tick();
        if (s_rvalid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle got %b exp 0", s_rvalid); end
        checks++;

        s_araddr = 32'h204; s_arvalid = 1'b1; s_rready = 1'b0;
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (!s_rvalid && n < 20) begin tick(); n++; end
        if (!s_rvalid) timeout_fail("stall_rvalid");
        for (int k = 0; k < 5; k++) begin
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h81) begin
                errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/00000081", k, s_rvalid, s_rdata);
            end
            checks++;
            tick();
        end
        s_rready = 1'b1;
        tick();
        if (s_rvalid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", s_rvalid); end
        checks++;
    endtask

    task automatic test_write_order();
        int n, bcount;
        logic [1:0]  bseen;
        logic [31:0] d;
        logic [1:0]  r;
        bd_write(32'h40, 32'h1122_3344, 4'hF);
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'b0011; s_wvalid = 1'b1; s_bready = 1'b1;
        if (s_wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got %b exp 1", s_wready); end
        checks++;
        tick();
        s_wvalid = 1'b0;
        if (s_wready !== 1'b0 || s_bvalid !== 1'b0) begin
            errors++; $display("FAIL wfirst_held got wready %b bvalid %b exp 0 0", s_wready, s_bvalid);
        end
        checks++;
        tick();
        s_awaddr = 32'h40; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        bcount = 0; bseen = 2'bxx;
        for (int k = 0; k < 6; k++) begin
            if (s_bvalid) begin bcount++; bseen = s_bresp; end
            tick();
        end
        if (bcount !== 1 || bseen !== 2'b00) begin
            errors++; $display("FAIL wfirst_b got %0d beats resp %b exp 1 beat resp 00", bcount, bseen);
        end
        checks++;
        axi_read(32'h40, d, r);
        if (d !== 32'h1122_BEEF) begin errors++; $display("FAIL wfirst_data got %h exp 1122beef", d); end
        checks++;

        s_awaddr = 32'h4C; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        if (s_awready !== 1'b0) begin errors++; $display("FAIL awfirst_held got %b exp 0", s_awready); end
        checks++;
        s_wdata = 32'h1234_5678; s_wstrb = 4'b1100; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        n = 0;
        while (!s_bvalid && n < 20) begin tick(); n++; end
        if (!s_bvalid) timeout_fail("awfirst_bvalid");
        tick();
        axi_read(32'h4C, d, r);
        if (d !== 32'h1234_0013) begin errors++; $display("FAIL awfirst_data got %h exp 12340013", d); end
        checks++;
    endtask

    task automatic test_backdoor();
        logic [31:0] d;
        logic [1:0]  r;
        bd_write(32'h80, 32'h2400_006F, 4'hF);
        axi_read(32'h80, d, r);
        if (d !== 32'h2400_006F) begin errors++; $display("FAIL bd_read got %h exp 2400006f", d); end
        checks++;
        s_awaddr = 32'h84; s_wdata = 32'hAAAA_AAAA; s_wstrb = 4'b0001;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        bd_addr = 32'h84; bd_wdata = 32'h5555_5555; bd_wstrb = 4'hF; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            errors++; $display("FAIL merge_b got %b/%b exp 1/00", s_bvalid, s_bresp);
        end
        checks++;
        tick();
        axi_read(32'h84, d, r);
        if (d !== 32'h5555_55AA) begin errors++; $display("FAIL merge_data got %h exp 555555aa", d); end
        checks++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        s_araddr = 32'h48; s_arvalid = 1'b1; s_rready = 1'b1; s_bready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        tick();
        s_awaddr = 32'h48; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h12 || s_bvalid !== 1'b1) begin
            errors++; $display("FAIL collide_old got rvalid %b rdata %h bvalid %b exp 1 00000012 1", s_rvalid, s_rdata, s_bvalid);
        end
        checks++;
        tick();
        axi_read(32'h48, d, r);
        if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL collide_new got %h exp cafef00d", d); end
        checks++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(32'h4000, d, r);
        if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL oor_read got %h/%b exp 00000000/10", d, r); end
        checks++;
        axi_write(32'h4000, 32'hFFFF_FFFF, 4'hF, r);
        if (r !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b exp 10", r); end
        checks++;
        bd_write(32'h4000, 32'hFFFF_FFFF, 4'hF);
        axi_read(32'h0, d, r);
        if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL oor_unchanged got %h/%b exp 00000000/00", d, r); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int   n;
        logic seen;
        logic [31:0] d;
        logic [1:0]  r;
        s_araddr = 32'h100; s_arvalid = 1'b1; s_rready = 1'b1;
        s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        tick();
        s_arvalid = 1'b0; s_wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        if ({s_rvalid, s_bvalid, init_done, s_arready, s_wready} !== 5'b0) begin
            errors++; $display("FAIL midrst_async got %b exp 00000", {s_rvalid, s_bvalid, init_done, s_arready, s_wready});
        end
        checks++;
        tick(); tick();
        rst_n = 1'b1;
        n = 0; seen = 1'b0;
        while (!init_done && n < 5000) begin
            tick(); n++;
            if (s_rvalid || s_bvalid) seen = 1'b1;
        end
        repeat (8) begin
            tick();
            if (s_rvalid || s_bvalid) seen = 1'b1;
        end
        if (n !== 4096) begin errors++; $display("FAIL midrst_init got %0d exp 4096", n); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_resp got %b exp 0", seen); end
        checks++;
        axi_read(32'h48, d, r);
        if (d !== 32'h12) begin errors++; $display("FAIL midrst_refill got %h exp 00000012", d); end
        checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; bd_wstrb = '0;
        test_reset();
        test_fill_read();
        test_read_latency();
        test_write_order();
        test_backdoor();
        test_collision();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
